// File: rtl/qam_symbol_scheduler_pkg.sv
// Shared types and constants for the QAM symbol scheduler.
// The state enum, the preamble symbols and a saturating counter helper live here.
package Structures;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } SCHED_STATE;

  localparam logic [3:0] PREAMBLE_SYM_A = 4'h0;
  localparam logic [3:0] PREAMBLE_SYM_B = 4'hF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/qam_symbol_scheduler_fifo.sv
// First-word-fall-through symbol buffer with occupancy and registered ready.
// Pushes into a full buffer and pops from an empty one are ignored here.
module SymbolFIFO #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic          ready_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem[rd_ptr_r];
  assign level     = level_r;
  assign ready     = ready_r;

  // Occupancy after this cycle's accepted push and pop.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s < LW'(DEPTH));
    end
  end

  // Storage array; contents are only meaningful below the level.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Paces buffered symbols to the QAM modulator, one every P clocks, behind a
// programmable alternating preamble; counts underflowed bursts and dropped pushes.
module qam_symbol_scheduler
  import Structures::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PERIOD_W   = 16
) (
  input  logic                          ipClk,
  input  logic                          ipReset,
  input  logic                          ipEnable,
  input  logic [PERIOD_W-1:0]           ipSymbolPeriod,
  input  logic [3:0]                    ipPreambleLen,
  input  logic [3:0]                    ipQAMBlock,
  input  logic                          ipQAMBlockValid,
  output logic                          opQAMBlockReady,
  output logic [3:0]                    opQAMBlock,
  output logic                          opQAMBlockValid,
  output logic                          opBusy,
  output logic [$clog2(FIFO_DEPTH):0]   opFIFO_Level,
  output logic [15:0]                   opUnderflowCount,
  output logic [15:0]                   opOverflowCount
);

  SCHED_STATE          state_r, state_n;
  logic [PERIOD_W-1:0] cnt_r, cnt_n;
  logic [PERIOD_W-1:0] reload_s;
  logic [3:0]          pre_left_r, pre_left_n;
  logic                pre_phase_r, pre_phase_n;
  logic [3:0]          sym_r, sym_n;
  logic                valid_r, valid_n;
  logic                busy_r, busy_n;
  logic [15:0]         und_r, und_n;
  logic [15:0]         ovf_r, ovf_n;
  logic                pop_s;
  logic [3:0]          head_s;
  logic                full_s;
  logic                empty_s;

  SymbolFIFO #(.DEPTH(FIFO_DEPTH), .W(4)) u_fifo (
    .clk   (ipClk),
    .rst_n (ipReset),
    .push  (ipQAMBlockValid),
    .pop   (pop_s),
    .din   (ipQAMBlock),
    .dout  (head_s),
    .level (opFIFO_Level),
    .full  (full_s),
    .empty (empty_s),
    .ready (opQAMBlockReady)
  );

  // Periods of 0 and 1 are clamped to 2; the counter reloads P-1.
  assign reload_s = ((ipSymbolPeriod < PERIOD_W'(2)) ? PERIOD_W'(2) : ipSymbolPeriod) - PERIOD_W'(1);

  // Next-state and strobe decisions; a strobe point is a zero count.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    pre_left_n  = pre_left_r;
    pre_phase_n = pre_phase_r;
    sym_n       = sym_r;
    valid_n     = 1'b0;
    und_n       = und_r;
    pop_s       = 1'b0;
    ovf_n       = (ipQAMBlockValid && full_s) ? sat_inc16(ovf_r) : ovf_r;
    case (state_r)
      IDLE: begin
        if (ipEnable && !empty_s) begin
          cnt_n       = reload_s;
          pre_left_n  = ipPreambleLen;
          pre_phase_n = 1'b0;
          state_n     = (ipPreambleLen == 4'd0) ? DATA : PREAMBLE;
        end else begin
          state_n = IDLE;
        end
      end
      PREAMBLE: begin
        if (cnt_r != {PERIOD_W{1'b0}}) begin
          cnt_n = cnt_r - PERIOD_W'(1);
        end else if (!ipEnable) begin
          state_n = IDLE;
        end else begin
          valid_n     = 1'b1;
          sym_n       = pre_phase_r ? PREAMBLE_SYM_B : PREAMBLE_SYM_A;
          pre_phase_n = ~pre_phase_r;
          pre_left_n  = pre_left_r - 4'd1;
          cnt_n       = reload_s;
          state_n     = (pre_left_r == 4'd1) ? DATA : PREAMBLE;
        end
      end
      DATA: begin
        if (cnt_r != {PERIOD_W{1'b0}}) begin
          cnt_n = cnt_r - PERIOD_W'(1);
        end else if (!ipEnable) begin
          state_n = IDLE;
        end else if (!empty_s) begin
          pop_s   = 1'b1;
          valid_n = 1'b1;
          sym_n   = head_s;
          cnt_n   = reload_s;
        end else begin
          und_n   = sat_inc16(und_r);
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_r     <= IDLE;
      cnt_r       <= {PERIOD_W{1'b0}};
      pre_left_r  <= 4'd0;
      pre_phase_r <= 1'b0;
      sym_r       <= 4'h0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      und_r       <= 16'd0;
      ovf_r       <= 16'd0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      pre_left_r  <= pre_left_n;
      pre_phase_r <= pre_phase_n;
      sym_r       <= sym_n;
      valid_r     <= valid_n;
      busy_r      <= busy_n;
      und_r       <= und_n;
      ovf_r       <= ovf_n;
    end
  end

  assign opQAMBlock       = sym_r;
  assign opQAMBlockValid  = valid_r;
  assign opBusy           = busy_r;
  assign opUnderflowCount = und_r;
  assign opOverflowCount  = ovf_r;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench for qam_symbol_scheduler: directed scenarios plus a
// randomized run against a queue-based, absolute-time reference model.
module tb_qam_symbol_scheduler;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          ipClk = 1'b0;
  logic          ipReset, ipEnable, ipQAMBlockValid;
  logic [15:0]   ipSymbolPeriod;
  logic [3:0]    ipPreambleLen, ipQAMBlock;
  logic          opQAMBlockReady, opQAMBlockValid, opBusy;
  logic [3:0]    opQAMBlock;
  logic [LW-1:0] opFIFO_Level;
  logic [15:0]   opUnderflowCount, opOverflowCount;

  always #5 ipClk = ~ipClk;

  qam_symbol_scheduler #(.FIFO_DEPTH(DEPTH), .PERIOD_W(16)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable),
    .ipSymbolPeriod(ipSymbolPeriod), .ipPreambleLen(ipPreambleLen),
    .ipQAMBlock(ipQAMBlock), .ipQAMBlockValid(ipQAMBlockValid),
    .opQAMBlockReady(opQAMBlockReady), .opQAMBlock(opQAMBlock),
    .opQAMBlockValid(opQAMBlockValid), .opBusy(opBusy),
    .opFIFO_Level(opFIFO_Level), .opUnderflowCount(opUnderflowCount),
    .opOverflowCount(opOverflowCount)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue, a burst flag and the absolute cycle of the next symbol.
  int       m_q[$];
  bit       m_active, m_valid, m_ready;
  int       m_due, m_pre_left, m_pre_sent, m_und, m_ovf, m_cyc;
  logic [3:0] m_sym;

  function automatic int eff_p();
    int p;
    p = int'(ipSymbolPeriod);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_valid = 0; m_ready = 0; m_sym = 4'h0;
    m_pre_left = 0; m_pre_sent = 0; m_und = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int lvl;
    m_cyc++;
    if (!ipReset) begin
      model_reset();
      return;
    end
    lvl = m_q.size();
    m_valid = 0;
    if (m_active) begin
      if (m_cyc == m_due) begin
        if (!ipEnable) m_active = 0;
        else if (m_pre_left > 0) begin
          m_valid = 1;
          m_sym = (m_pre_sent % 2 == 0) ? 4'h0 : 4'hF;
          m_pre_sent++; m_pre_left--;
          m_due = m_cyc + eff_p();
        end else if (lvl > 0) begin
          m_valid = 1;
          m_sym = 4'(m_q.pop_front());
          m_due = m_cyc + eff_p();
        end else begin
          if (m_und < 65535) m_und++;
          m_active = 0;
        end
      end
    end else if (ipEnable && lvl > 0) begin
      m_active = 1; m_due = m_cyc + eff_p();
      m_pre_left = int'(ipPreambleLen); m_pre_sent = 0;
    end
    if (ipQAMBlockValid) begin
      if (lvl < DEPTH) m_q.push_back(int'(ipQAMBlock));
      else if (m_ovf < 65535) m_ovf++;
    end
    m_ready = (m_q.size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge ipClk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    ipReset = 1'b0; ipEnable = 1'b0; ipQAMBlockValid = 1'b0; ipQAMBlock = 4'h0;
    model_reset();
    repeat (2) tick();
    ipReset = 1'b1;
    tick();
  endtask

  task automatic push_sym(input logic [3:0] v);
    ipQAMBlock = v; ipQAMBlockValid = 1'b1;
    tick();
    ipQAMBlockValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [43:0] got;
    ipReset = 1'b0; ipEnable = 1'b1; ipQAMBlockValid = 1'b0;
    ipQAMBlock = 4'h0; ipSymbolPeriod = 16'd4; ipPreambleLen = 4'd2;
    repeat (3) tick();
    got = {opQAMBlockValid, opQAMBlock, opBusy, opQAMBlockReady, opFIFO_Level, opUnderflowCount, opOverflowCount};
    n_vec++;
    if (got !== 44'h0) begin n_err++; $display("FAIL reset_outputs: got %h want %h", got, 44'h0); end
    ipReset = 1'b1; ipEnable = 1'b0;
    tick();
    n_vec++;
    if (opQAMBlockReady !== 1'b1) begin n_err++; $display("FAIL reset_ready_rise: got %b want 1", opQAMBlockReady); end
  endtask

  task automatic test_burst();
    logic [3:0] exp_s[5] = '{4'h0, 4'hF, 4'h3, 4'h7, 4'h9};
    int         exp_t[5] = '{5, 9, 13, 17, 21};
    logic [3:0] sy[$];
    int         tt[$];
    do_reset();
    ipSymbolPeriod = 16'd4; ipPreambleLen = 4'd2;
    push_sym(4'h3); push_sym(4'h7); push_sym(4'h9);
    ipEnable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (opQAMBlockValid) begin sy.push_back(opQAMBlock); tt.push_back(k); end
      if (!opBusy) break;
    end
    n_vec++;
    if (sy.size() != 5) begin n_err++; $display("FAIL burst_count: got %0d want 5", sy.size()); end
    for (int i = 0; i < 5 && i < sy.size(); i++) begin
      n_vec++;
      if (sy[i] !== exp_s[i] || tt[i] != exp_t[i]) begin
        n_err++; $display("FAIL burst_sym%0d: got %h@%0d want %h@%0d", i, sy[i], tt[i], exp_s[i], exp_t[i]);
      end
    end
    n_vec++;
    if ({opUnderflowCount, opBusy} !== {16'd1, 1'b0}) begin
      n_err++; $display("FAIL burst_underflow: got und=%0d busy=%b want und=1 busy=0", opUnderflowCount, opBusy);
    end
  endtask

  task automatic test_min_period();
    int tt[$];
    for (int pp = 0; pp < 2; pp++) begin
      tt.delete();
      do_reset();
      ipSymbolPeriod = 16'(pp); ipPreambleLen = 4'd0;
      push_sym(4'h1); push_sym(4'h2); push_sym(4'h4);
      ipEnable = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (opQAMBlockValid) tt.push_back(k);
      end
      n_vec++;
      if (tt.size() != 3 || tt[0] != 3 || tt[1] != 5 || tt[2] != 7) begin
        n_err++; $display("FAIL min_period_p%0d: got %0d strobes first@%0d want 3 strobes at 3,5,7", pp, tt.size(), (tt.size() > 0) ? tt[0] : -1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] pushed[18];
    logic [3:0] sy[$];
    do_reset();
    ipSymbolPeriod = 16'd2; ipPreambleLen = 4'd0;
    for (int i = 0; i < 18; i++) begin
      pushed[i] = 4'($urandom_range(0, 15));
      push_sym(pushed[i]);
    end
    n_vec++;
    if ({opFIFO_Level, opOverflowCount, opQAMBlockReady} !== {5'd16, 16'd2, 1'b0}) begin
      n_err++; $display("FAIL overflow_full: got lvl=%0d ovf=%0d rdy=%b want 16 2 0", opFIFO_Level, opOverflowCount, opQAMBlockReady);
    end
    ipEnable = 1'b1;
    for (int k = 0; k < 100 && opUnderflowCount == 16'd0; k++) begin
      tick();
      if (opQAMBlockValid) sy.push_back(opQAMBlock);
    end
    n_vec++;
    if (sy.size() != 16) begin n_err++; $display("FAIL overflow_drain_count: got %0d want 16", sy.size()); end
    for (int i = 0; i < 16 && i < sy.size(); i++) begin
      n_vec++;
      if (sy[i] !== pushed[i]) begin n_err++; $display("FAIL overflow_order%0d: got %h want %h", i, sy[i], pushed[i]); end
    end
  endtask

  task automatic test_disable_mid();
    int seen, after;
    logic [3:0] sy[$];
    do_reset();
    ipSymbolPeriod = 16'd3; ipPreambleLen = 4'd0;
    for (int i = 0; i < 8; i++) push_sym(4'(i + 1));
    ipEnable = 1'b1;
    seen = 0;
    for (int k = 0; k < 50 && seen < 3; k++) begin
      tick();
      if (opQAMBlockValid) seen++;
    end
    ipEnable = 1'b0;
    after = 0;
    for (int k = 0; k < 10 && opBusy; k++) begin
      tick();
      if (opQAMBlockValid) after++;
    end
    n_vec++;
    if (seen != 3 || after != 0 || opBusy !== 1'b0 || opFIFO_Level !== 5'd5) begin
      n_err++; $display("FAIL disable_mid: got seen=%0d after=%0d busy=%b lvl=%0d want 3 0 0 5", seen, after, opBusy, opFIFO_Level);
    end
    ipPreambleLen = 4'd2; ipEnable = 1'b1;
    for (int k = 0; k < 30 && sy.size() < 3; k++) begin
      tick();
      if (opQAMBlockValid) sy.push_back(opQAMBlock);
    end
    n_vec++;
    if (sy.size() != 3 || sy[0] !== 4'h0 || sy[1] !== 4'hF || sy[2] !== 4'h4) begin
      n_err++; $display("FAIL reenable_preamble: got %0d syms first=%h want 0,F,4", sy.size(), (sy.size() > 0) ? sy[0] : 4'hx);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    ipSymbolPeriod = 16'd2; ipPreambleLen = 4'd0;
    for (int i = 0; i < 16; i++) push_sym(4'(i));
    ipEnable = 1'b1;
    tick();
    tick();
    ipQAMBlock = 4'h5; ipQAMBlockValid = 1'b1;
    tick();
    ipQAMBlockValid = 1'b0;
    n_vec++;
    if ({opQAMBlockValid, opQAMBlock, opFIFO_Level, opOverflowCount} !== {1'b1, 4'h0, 5'd15, 16'd1}) begin
      n_err++; $display("FAIL full_push_pop: got v=%b s=%h lvl=%0d ovf=%0d want 1 0 15 1", opQAMBlockValid, opQAMBlock, opFIFO_Level, opOverflowCount);
    end
  endtask

  task automatic test_reset_mid_preamble();
    logic [43:0] got;
    int strobes;
    do_reset();
    ipSymbolPeriod = 16'd3; ipPreambleLen = 4'd6;
    push_sym(4'hA); push_sym(4'hB);
    ipEnable = 1'b1;
    for (int k = 0; k < 20 && !opQAMBlockValid; k++) tick();
    n_vec++;
    if ({opQAMBlockValid, opQAMBlock, opBusy} !== {1'b1, 4'h0, 1'b1}) begin
      n_err++; $display("FAIL mid_preamble_first: got v=%b s=%h busy=%b want 1 0 1", opQAMBlockValid, opQAMBlock, opBusy);
    end
    #2 ipReset = 1'b0;
    model_reset();
    #1;
    got = {opQAMBlockValid, opQAMBlock, opBusy, opQAMBlockReady, opFIFO_Level, opUnderflowCount, opOverflowCount};
    n_vec++;
    if (got !== 44'h0) begin n_err++; $display("FAIL async_reset: got %h want %h", got, 44'h0); end
    repeat (2) tick();
    ipReset = 1'b1;
    strobes = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (opQAMBlockValid || opBusy) strobes++;
    end
    n_vec++;
    if (strobes != 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", strobes); end
  endtask

  task automatic test_random();
    logic [43:0] got, exp;
    int rate;
    do_reset();
    ipSymbolPeriod = 16'd3; ipPreambleLen = 4'd2; ipEnable = 1'b1; rate = 40;
    for (int c = 0; c < 2400; c++) begin
      if (c % 200 == 0) rate = (c % 600 == 0) ? 5 : ((c % 400 == 0) ? 90 : 40);
      ipQAMBlockValid = ($urandom_range(0, 99) < rate);
      ipQAMBlock = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) ipEnable = ~ipEnable;
      if ($urandom_range(0, 99) < 5) ipSymbolPeriod = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 5) ipPreambleLen = 4'($urandom_range(0, 4));
      tick();
      got = {opQAMBlockValid, opQAMBlock, opBusy, opQAMBlockReady, opFIFO_Level, opUnderflowCount, opOverflowCount};
      exp = {m_valid, m_sym, m_active, m_ready, LW'(m_q.size()), 16'(m_und), 16'(m_ovf)};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL random_cycle%0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    test_reset();
    test_burst();
    test_min_period();
    test_overflow();
    test_disable_mid();
    test_full_push_pop();
    test_reset_mid_preamble();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
